// File: rtl/delay_line_prog.sv
// Programmable tap delay line with fill tracking and a registered delay select.
// Latency: dataOut = dataIn from selReg enabled edges earlier (0 = combinational passthrough).
// Backpressure: none; en=0 freezes the line, the fill count and the frozen output.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (taps and fill count cleared)
//   en         shift enable; the line advances only when high
//   delaySel   requested delay in enabled cycles, clamped to MAX_DELAY
//   dataIn     sample entering the line
//   dataOut    sample at the selected tap (dataIn when the delay is 0)
//   dataValid  high once the line holds selReg genuine samples since the last reset/change
module delay_line_prog #(
  parameter int WIDTH     = 1,
  parameter int MAX_DELAY = 16,
  parameter int SELW      = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SELW-1:0]  delaySel,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid
);

  localparam logic [SELW-1:0] MAX_SEL = SELW'(MAX_DELAY);

  // Tap k holds the sample entered k enabled edges ago.
  logic [WIDTH-1:0] r_tap [1:MAX_DELAY];
  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_fill;

  logic [SELW-1:0]  w_sel_clamp;
  logic             w_change;
  logic [WIDTH-1:0] w_tap_sel;

  // Requests beyond the deepest tap behave exactly as the deepest tap.
  assign w_sel_clamp = (delaySel > MAX_SEL) ? MAX_SEL : delaySel;

  // A new request restarts the fill count, even when en is low.
  assign w_change = (w_sel_clamp != r_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        r_tap[k] <= '0;
      end
      r_fill <= '0;
      r_sel  <= w_sel_clamp;
    end else begin
      r_sel <= w_sel_clamp;

      if (en) begin
        r_tap[1] <= dataIn;
        for (int k = 2; k <= MAX_DELAY; k++) begin
          r_tap[k] <= r_tap[k-1];
        end
      end

      // Change detection wins over the increment; the count saturates at the
      // current delay so it never wraps back to an invalid state.
      if (w_change) begin
        r_fill <= '0;
      end else if (en && (r_fill < r_sel)) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Decoded tap select; r_sel is always within 0..MAX_DELAY thanks to the clamp.
  always_comb begin
    w_tap_sel = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (r_sel == SELW'(k)) begin
        w_tap_sel = r_tap[k];
      end
    end
  end

  assign dataOut   = (r_sel == '0) ? dataIn : w_tap_sel;
  assign dataValid = (r_fill >= r_sel);

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed bench for delay_line_prog (WIDTH=8, MAX_DELAY=16): a vector table for
// fill-up and a delay change, then hand sequences for passthrough, stall,
// clamping and mid-fill reset.
module tb_delay_line_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] delaySel;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       dataValid;

  int n_cmp;
  int n_bad;

  delay_line_prog #(
    .WIDTH     (8),
    .MAX_DELAY (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .delaySel  (delaySel),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .dataValid (dataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [4:0] sel;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_vld;
  } vec_t;

  vec_t tbl[$];

  // Drive inputs on the falling edge, then look at outputs just after the rising edge.
  task automatic step(input logic r, input logic e, input logic [4:0] s, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    en       = e;
    delaySel = s;
    dataIn   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] eo);
    n_cmp++;
    if (dataOut !== eo) begin
      n_bad++;
      $display("FAIL %s dataOut: got %0d want %0d", nm, dataOut, eo);
    end
  endtask

  task automatic chk_vld(input string nm, input logic ev);
    n_cmp++;
    if (dataValid !== ev) begin
      n_bad++;
      $display("FAIL %s dataValid: got %0b want %0b", nm, dataValid, ev);
    end
  endtask

  function automatic vec_t mk(logic r, logic e, logic [4:0] s, logic [7:0] d,
                              logic [7:0] eo, logic ev);
    vec_t v;
    v.rst = r; v.en = e; v.sel = s; v.din = d; v.exp_out = eo; v.exp_vld = ev;
    return v;
  endfunction

  initial begin
    logic [7:0] d;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    en       = 1'b0;
    delaySel = '0;
    dataIn   = '0;

    // Reset with delay 7, then fill with 1,2,3...: output 0 and invalid until
    // the 7th enabled edge delivers sample 1.
    tbl.push_back(mk(1'b1, 1'b0, 5'd7, 8'd0, 8'd0, 1'b0));
    for (int k = 1; k <= 14; k++) begin
      tbl.push_back(mk(1'b0, 1'b1, 5'd7, 8'(k),
                       (k >= 7) ? 8'(k - 6) : 8'd0, (k >= 7)));
    end
    // Switch to delay 3 at sample 15: invalid on the detecting edge, valid three
    // enabled edges later; the output is always the sample three edges back.
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 8'd15, 8'd13, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 8'd16, 8'd14, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 8'd17, 8'd15, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 8'd18, 8'd16, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 8'd19, 8'd17, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].din);
      chk_out($sformatf("vec%0d", i), tbl[i].exp_out);
      chk_vld($sformatf("vec%0d", i), tbl[i].exp_vld);
    end

    // Delay 0: same-cycle passthrough, valid immediately from the detecting edge.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, 5'd0, d);
      chk_out($sformatf("pass%0d", i), d);
      chk_vld($sformatf("pass%0d", i), 1'b1);
    end

    // Delay 5 with samples 100..107, then a 4-cycle stall, then resume.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 5'd5, 8'(100 + i));
      chk_vld($sformatf("d5fill%0d", i), (i >= 5));
      if (i >= 5) chk_out($sformatf("d5fill%0d", i), 8'(96 + i));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 5'd5, 8'hEE);
      chk_out($sformatf("stall%0d", i), 8'd103);
      chk_vld($sformatf("stall%0d", i), 1'b1);
    end
    step(1'b0, 1'b1, 5'd5, 8'd108);
    chk_out("resume0", 8'd104);
    chk_vld("resume0", 1'b1);
    step(1'b0, 1'b1, 5'd5, 8'd109);
    chk_out("resume1", 8'd105);

    // Reset with delay 0: output is the live input and valid is high.
    step(1'b1, 1'b1, 5'd0, 8'h5A);
    chk_out("rst_sel0", 8'h5A);
    chk_vld("rst_sel0", 1'b1);

    // Request 20 clamps to 16: valid after 16 enabled edges, latency 16.
    step(1'b1, 1'b0, 5'd20, 8'd0);
    chk_out("clamp_rst", 8'd0);
    chk_vld("clamp_rst", 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 1'b1, 5'd20, 8'(k));
      chk_vld($sformatf("clamp%0d", k), (k >= 16));
      chk_out($sformatf("clamp%0d", k), (k >= 16) ? 8'(k - 15) : 8'd0);
    end

    // Delay 10, reset after 6 enabled edges: old samples must never reappear.
    step(1'b1, 1'b0, 5'd10, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, 5'd10, 8'(50 + k));
    end
    step(1'b1, 1'b1, 5'd10, 8'd99);
    chk_out("midrst", 8'd0);
    chk_vld("midrst", 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 5'd10, 8'(200 + k));
      chk_vld($sformatf("refill%0d", k), (k >= 10));
      chk_out($sformatf("refill%0d", k), (k >= 10) ? 8'd201 : 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
